// File: rtl/vga_pkg.sv
// Shared timing defaults, derived-size helpers and the pixel payload layout.
package vga_pkg;

  localparam int unsigned DEF_RED_WIDTH      = 4;
  localparam int unsigned DEF_GREEN_WIDTH    = 4;
  localparam int unsigned DEF_BLUE_WIDTH     = 4;

  localparam int unsigned DEF_H_VISIBLE_AREA = 640;
  localparam int unsigned DEF_H_FRONT_PORCH  = 16;
  localparam int unsigned DEF_H_SYNC_PULSE   = 96;
  localparam int unsigned DEF_H_BACK_PORCH   = 48;

  localparam int unsigned DEF_V_VISIBLE_AREA = 480;
  localparam int unsigned DEF_V_FRONT_PORCH  = 10;
  localparam int unsigned DEF_V_SYNC_PULSE   = 2;
  localparam int unsigned DEF_V_BACK_PORCH   = 33;

  // Pixel word in display order, red in the MSBs.
  typedef struct packed {
    logic [DEF_RED_WIDTH-1:0]   red;
    logic [DEF_GREEN_WIDTH-1:0] green;
    logic [DEF_BLUE_WIDTH-1:0]  blue;
  } pixel_t;

  // Total clocks (or lines) in one scan period.
  function automatic int unsigned line_len(input int unsigned vis, input int unsigned fp,
                                           input int unsigned sp, input int unsigned bp);
    return vis + fp + sp + bp;
  endfunction

  // Number of framebuffer words covering the visible area.
  function automatic int unsigned mem_size(input int unsigned h_vis, input int unsigned v_vis);
    return h_vis * v_vis;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters, visible/sync decode and column-major framebuffer read address.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE_AREA = DEF_H_VISIBLE_AREA,
  parameter int unsigned H_FRONT_PORCH  = DEF_H_FRONT_PORCH,
  parameter int unsigned H_SYNC_PULSE   = DEF_H_SYNC_PULSE,
  parameter int unsigned H_BACK_PORCH   = DEF_H_BACK_PORCH,
  parameter int unsigned V_VISIBLE_AREA = DEF_V_VISIBLE_AREA,
  parameter int unsigned V_FRONT_PORCH  = DEF_V_FRONT_PORCH,
  parameter int unsigned V_SYNC_PULSE   = DEF_V_SYNC_PULSE,
  parameter int unsigned V_BACK_PORCH   = DEF_V_BACK_PORCH,
  parameter int unsigned RD_W           = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            visible_c,
  output logic            h_sync_c,
  output logic            v_sync_c,
  output logic [RD_W-1:0] rd_addr
);

  localparam int unsigned H_LINE = line_len(H_VISIBLE_AREA, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
  localparam int unsigned V_LINE = line_len(V_VISIBLE_AREA, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);
  localparam int unsigned HW     = (H_LINE > 1) ? $clog2(H_LINE) : 1;
  localparam int unsigned VW     = (V_LINE > 1) ? $clog2(V_LINE) : 1;

  localparam int unsigned H_SYNC_START = H_VISIBLE_AREA + H_FRONT_PORCH;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_PULSE;
  localparam int unsigned V_SYNC_START = V_VISIBLE_AREA + V_FRONT_PORCH;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_PULSE;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  // Advance the raster; rd_addr tracks h_cnt*V_VISIBLE_AREA + v_cnt by stepping one column per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      rd_addr <= '0;
    end else if (h_cnt == HW'(H_LINE - 1)) begin
      h_cnt <= '0;
      if (v_cnt == VW'(V_LINE - 1)) begin
        v_cnt   <= '0;
        rd_addr <= '0;
      end else begin
        v_cnt   <= v_cnt + VW'(1);
        rd_addr <= RD_W'(v_cnt) + RD_W'(1);
      end
    end else begin
      h_cnt   <= h_cnt + HW'(1);
      rd_addr <= rd_addr + RD_W'(V_VISIBLE_AREA);
    end
  end

  // Decode visible window and active-low sync pulses from the current counters.
  always_comb begin
    visible_c = (32'(h_cnt) < H_VISIBLE_AREA) && (32'(v_cnt) < V_VISIBLE_AREA);
    h_sync_c  = !((32'(h_cnt) >= H_SYNC_START) && (32'(h_cnt) < H_SYNC_END));
    v_sync_c  = !((32'(v_cnt) >= V_SYNC_START) && (32'(v_cnt) < V_SYNC_END));
  end

endmodule

// File: rtl/vga_framebuffer_display.sv
// Framebuffer RAM plus timing generator driving registered RGB and sync outputs.
module vga_framebuffer_display
  import vga_pkg::*;
#(
  parameter int unsigned RED_WIDTH      = DEF_RED_WIDTH,
  parameter int unsigned GREEN_WIDTH    = DEF_GREEN_WIDTH,
  parameter int unsigned BLUE_WIDTH     = DEF_BLUE_WIDTH,
  parameter int unsigned H_VISIBLE_AREA = DEF_H_VISIBLE_AREA,
  parameter int unsigned H_FRONT_PORCH  = DEF_H_FRONT_PORCH,
  parameter int unsigned H_SYNC_PULSE   = DEF_H_SYNC_PULSE,
  parameter int unsigned H_BACK_PORCH   = DEF_H_BACK_PORCH,
  parameter int unsigned V_VISIBLE_AREA = DEF_V_VISIBLE_AREA,
  parameter int unsigned V_FRONT_PORCH  = DEF_V_FRONT_PORCH,
  parameter int unsigned V_SYNC_PULSE   = DEF_V_SYNC_PULSE,
  parameter int unsigned V_BACK_PORCH   = DEF_V_BACK_PORCH
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        write_enable,
  input  logic [31:0]                                 write_addr,
  input  logic [RED_WIDTH+GREEN_WIDTH+BLUE_WIDTH-1:0] pixel_in,
  output logic [RED_WIDTH+GREEN_WIDTH+BLUE_WIDTH-1:0] pixel_out,
  output logic                                        h_sync,
  output logic                                        v_sync
);

  localparam int unsigned PIXEL_WIDTH = RED_WIDTH + GREEN_WIDTH + BLUE_WIDTH;
  localparam int unsigned H_LINE      = line_len(H_VISIBLE_AREA, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
  localparam int unsigned V_LINE      = line_len(V_VISIBLE_AREA, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);
  localparam int unsigned MEM_SIZE    = mem_size(H_VISIBLE_AREA, V_VISIBLE_AREA);
  localparam int unsigned ADDR_W      = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  // rd_addr keeps stepping through the blanking columns, so size it for the full line.
  localparam int unsigned RD_W        = $clog2(H_LINE * V_VISIBLE_AREA + V_LINE);

  logic [PIXEL_WIDTH-1:0] ram [MEM_SIZE];

  logic            visible_c;
  logic            h_sync_c;
  logic            v_sync_c;
  logic [RD_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_idx_c;

  vga_timing_gen #(
    .H_VISIBLE_AREA (H_VISIBLE_AREA),
    .H_FRONT_PORCH  (H_FRONT_PORCH),
    .H_SYNC_PULSE   (H_SYNC_PULSE),
    .H_BACK_PORCH   (H_BACK_PORCH),
    .V_VISIBLE_AREA (V_VISIBLE_AREA),
    .V_FRONT_PORCH  (V_FRONT_PORCH),
    .V_SYNC_PULSE   (V_SYNC_PULSE),
    .V_BACK_PORCH   (V_BACK_PORCH),
    .RD_W           (RD_W)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .visible_c (visible_c),
    .h_sync_c  (h_sync_c),
    .v_sync_c  (v_sync_c),
    .rd_addr   (rd_addr)
  );

  // Host write port; independent of reset so a frame can be preloaded while held in reset.
  always_ff @(posedge clk) begin
    if (write_enable && (write_addr < MEM_SIZE)) begin
      ram[write_addr[ADDR_W-1:0]] <= pixel_in;
    end
  end

  // Park the read index at 0 during blanking so it never leaves the array.
  always_comb begin
    rd_idx_c = visible_c ? ADDR_W'(rd_addr) : '0;
  end

  // Output stage: RAM read (old data on a same-address write) aligned with the sync decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out <= '0;
      h_sync    <= 1'b1;
      v_sync    <= 1'b1;
    end else begin
      pixel_out <= visible_c ? ram[rd_idx_c] : '0;
      h_sync    <= h_sync_c;
      v_sync    <= v_sync_c;
    end
  end

endmodule

// File: tb/tb_vga_framebuffer_display.sv
// Scoreboard bench for vga_framebuffer_display on a reduced 32x24 raster.
module tb_vga_framebuffer_display;
  import vga_pkg::*;

  localparam int HV  = 32;
  localparam int HFP = 5;
  localparam int HSP = 5;
  localparam int HBP = 5;
  localparam int VV  = 24;
  localparam int VFP = 5;
  localparam int VSP = 5;
  localparam int VBP = 5;
  localparam int H_LINE = HV + HFP + HSP + HBP;   // 47
  localparam int V_LINE = VV + VFP + VSP + VBP;   // 39
  localparam int FRAME  = H_LINE * V_LINE;        // 1833
  localparam int MEM    = HV * VV;                // 768

  typedef struct {
    pixel_t pix;
    logic   hs;
    logic   vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [31:0] write_addr;
  logic [11:0] pixel_in;
  logic [11:0] pixel_out;
  logic        h_sync;
  logic        v_sync;

  exp_t        exp_q[$];
  logic [11:0] mem_m [MEM];
  int          m_h = 0;
  int          m_v = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  vga_framebuffer_display #(
    .RED_WIDTH      (4),
    .GREEN_WIDTH    (4),
    .BLUE_WIDTH     (4),
    .H_VISIBLE_AREA (HV),
    .H_FRONT_PORCH  (HFP),
    .H_SYNC_PULSE   (HSP),
    .H_BACK_PORCH   (HBP),
    .V_VISIBLE_AREA (VV),
    .V_FRONT_PORCH  (VFP),
    .V_SYNC_PULSE   (VSP),
    .V_BACK_PORCH   (VBP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .pixel_in     (pixel_in),
    .pixel_out    (pixel_out),
    .h_sync       (h_sync),
    .v_sync       (v_sync)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(input int a);
    return 12'(a * 5 + 1);
  endfunction

  // Predict the outputs of the coming edge, update the model, then step to the next falling edge.
  task automatic tick();
    exp_t e;
    if (reset) begin
      e.pix = '0;
      e.hs  = 1'b1;
      e.vs  = 1'b1;
    end else begin
      e.pix = (m_h < HV && m_v < VV) ? pixel_t'(mem_m[m_h * VV + m_v]) : pixel_t'(12'h000);
      e.hs  = !(m_h >= HV + HFP && m_h < HV + HFP + HSP);
      e.vs  = !(m_v >= VV + VFP && m_v < VV + VFP + VSP);
    end
    exp_q.push_back(e);
    if (write_enable && write_addr < 32'(MEM)) mem_m[int'(write_addr)] = pixel_in;
    if (reset) begin
      m_h = 0;
      m_v = 0;
    end else if (m_h == H_LINE - 1) begin
      m_h = 0;
      m_v = (m_v == V_LINE - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    reset        = 1'b1;
    write_enable = 1'b1;
    for (int a = 0; a < MEM; a++) begin
      write_addr = 32'(a);
      pixel_in   = pat(a);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (pixel_out !== e.pix || h_sync !== e.hs || v_sync !== e.vs) begin
        n_errors++;
        $display("FAIL reset_out a=%0d got pix=%h hs=%b vs=%b want pix=%h hs=%b vs=%b",
                 a, pixel_out, h_sync, v_sync, e.pix, e.hs, e.vs);
      end
    end
    write_enable = 1'b0;
  endtask

  task automatic test_frame();
    exp_t e;
    int   hs_low = 0;
    int   vs_low = 0;
    reset = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (pixel_out !== e.pix || h_sync !== e.hs || v_sync !== e.vs) begin
        n_errors++;
        $display("FAIL frame i=%0d got pix=%h hs=%b vs=%b want pix=%h hs=%b vs=%b",
                 i, pixel_out, h_sync, v_sync, e.pix, e.hs, e.vs);
      end
      if (i == 0) begin
        n_checks++;
        if (pixel_out !== 12'h001) begin
          n_errors++;
          $display("FAIL first_pixel got %h want 001", pixel_out);
        end
      end
      if (h_sync === 1'b0) hs_low++;
      if (v_sync === 1'b0) vs_low++;
    end
    n_checks++;
    if (hs_low != HSP * V_LINE) begin
      n_errors++;
      $display("FAIL hsync_low_count got %0d want %0d", hs_low, HSP * V_LINE);
    end
    n_checks++;
    if (vs_low != VSP * H_LINE) begin
      n_errors++;
      $display("FAIL vsync_low_count got %0d want %0d", vs_low, VSP * H_LINE);
    end
  endtask

  task automatic test_late_write();
    exp_t e;
    int   n;
    n = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      // (1,1) is scanned at cycle 48; write after it, plus two out-of-range writes.
      write_enable = (i >= 60 && i < 63);
      write_addr   = (i == 60) ? 32'd25 : (i == 61) ? 32'(MEM) : 32'(1024 + 25);
      pixel_in     = (i == 60) ? 12'hABC : 12'h123;
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (pixel_out !== e.pix || h_sync !== e.hs || v_sync !== e.vs) begin
        n_errors++;
        $display("FAIL late_write i=%0d got pix=%h hs=%b vs=%b want pix=%h hs=%b vs=%b",
                 i, pixel_out, h_sync, v_sync, e.pix, e.hs, e.vs);
      end
      if (i == FRAME + 48) begin
        n_checks++;
        if (pixel_out !== 12'hABC) begin
          n_errors++;
          $display("FAIL late_write_next_frame got %h want abc", pixel_out);
        end
      end
      n++;
    end
    write_enable = 1'b0;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    bit   hit = 1'b0;
    for (int i = 0; i < FRAME && !hit; i++) begin
      if (m_h == 20 && m_v == 3) begin
        hit = 1'b1;
      end else begin
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (pixel_out !== e.pix || h_sync !== e.hs || v_sync !== e.vs) begin
          n_errors++;
          $display("FAIL pre_reset i=%0d got pix=%h want pix=%h", i, pixel_out, e.pix);
        end
      end
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL mid_reset_position got h=%0d v=%0d want h=20 v=3", m_h, m_v);
    end
    reset = 1'b1;
    for (int i = 0; i < 2 * H_LINE + 11; i++) begin
      tick();
      reset = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (pixel_out !== e.pix || h_sync !== e.hs || v_sync !== e.vs) begin
        n_errors++;
        $display("FAIL mid_reset i=%0d got pix=%h hs=%b vs=%b want pix=%h hs=%b vs=%b",
                 i, pixel_out, h_sync, v_sync, e.pix, e.hs, e.vs);
      end
      if (i == 1) begin
        n_checks++;
        if (pixel_out !== pat(0)) begin
          n_errors++;
          $display("FAIL mid_reset_restart got %h want %h", pixel_out, pat(0));
        end
      end
    end
  endtask

  task automatic test_same_addr();
    exp_t e;
    reset = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (pixel_out !== 12'h000 || h_sync !== 1'b1 || v_sync !== 1'b1) begin
      n_errors++;
      $display("FAIL same_addr_reset got pix=%h hs=%b vs=%b want pix=000 hs=1 vs=1",
               pixel_out, h_sync, v_sync);
    end
    reset        = 1'b0;
    write_enable = 1'b1;
    write_addr   = 32'd0;
    pixel_in     = 12'h5A5;
    for (int i = 0; i <= FRAME; i++) begin
      tick();
      write_enable = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (pixel_out !== e.pix || h_sync !== e.hs || v_sync !== e.vs) begin
        n_errors++;
        $display("FAIL same_addr i=%0d got pix=%h hs=%b vs=%b want pix=%h hs=%b vs=%b",
                 i, pixel_out, h_sync, v_sync, e.pix, e.hs, e.vs);
      end
      if (i == 0 || i == FRAME) begin
        n_checks++;
        if (pixel_out !== ((i == 0) ? pat(0) : 12'h5A5)) begin
          n_errors++;
          $display("FAIL same_addr_rw i=%0d got %h want %h", i, pixel_out,
                   (i == 0) ? pat(0) : 12'h5A5);
        end
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    write_enable = 1'b0;
    write_addr   = '0;
    pixel_in     = '0;
    test_reset();
    test_frame();
    test_late_write();
    test_mid_reset();
    test_same_addr();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_framebuffer_display.md
Name: vga_framebuffer_display

Overview:
Framebuffer-backed VGA output block with a parameterised timing generator. A host writes pixels through a simple write port into an internal dual-port RAM sized to the visible area. The block scans the RAM and drives RGB pixel data plus h_sync/v_sync to the display. It sits between the pixel producer and the DAC/pins.

Parameters:
RED_WIDTH, 4, bits of red per pixel
GREEN_WIDTH, 4, bits of green per pixel
BLUE_WIDTH, 4, bits of blue per pixel
H_VISIBLE_AREA, 640, visible pixels per line
H_FRONT_PORCH, 16, pixel clocks of horizontal front porch
H_SYNC_PULSE, 96, pixel clocks of horizontal sync
H_BACK_PORCH, 48, pixel clocks of horizontal back porch
V_VISIBLE_AREA, 480, visible lines per frame
V_FRONT_PORCH, 10, lines of vertical front porch
V_SYNC_PULSE, 2, lines of vertical sync
V_BACK_PORCH, 33, lines of vertical back porch
(derived) PIXEL_WIDTH = R+G+B; H_LINE = sum of H_*; V_LINE = sum of V_*; MEM_SIZE = H_VISIBLE_AREA*V_VISIBLE_AREA

Ports:
clk  in  1  pixel clock; single clock domain
reset  in  1  synchronous, active-high reset
write_enable  in  1  write strobe, sampled on rising clk
write_addr  in  32  framebuffer address, addr = x*V_VISIBLE_AREA + y (column-major)
pixel_in  in  PIXEL_WIDTH  write data {red, green, blue}, red in MSBs
pixel_out  out  PIXEL_WIDTH  displayed pixel {red, green, blue}
h_sync  out  1  horizontal sync, active low
v_sync  out  1  vertical sync, active low

Behaviour:
- Write port: on posedge with write_enable=1 and write_addr < MEM_SIZE, RAM[write_addr] <= pixel_in. Out-of-range writes are ignored. Writes are accepted regardless of reset (frame loading during reset is a supported use).
- Counters: h_cnt 0..H_LINE-1, v_cnt 0..V_LINE-1. While reset=1 both are held at 0. Each posedge with reset=0: h_cnt increments; at H_LINE-1 it wraps to 0 and v_cnt increments; v_cnt wraps from V_LINE-1 to 0.
- Visible when h_cnt < H_VISIBLE_AREA and v_cnt < V_VISIBLE_AREA.
- Read address: h_cnt*V_VISIBLE_AREA + v_cnt. It may be maintained incrementally; no multiplier is required.
- Sync decode: h_sync=0 when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SP, else 1. v_sync uses the same rule on v_cnt.
- Latency: one cycle. Outputs registered on a given edge reflect the counter values held just before that edge. pixel_out = RAM[read addr] when visible, else 0. Syncs are registered in the same stage so pixel_out, h_sync and v_sync stay aligned.
- Reset values (outputs while reset=1): pixel_out=0, h_sync=1, v_sync=1. The first posedge after reset deasserts outputs pixel (0,0).
- Simultaneous write and read of the same address returns the old data (read-first); the new value is shown next frame. No X ever propagates to pixel_out for addresses written at least once. Unwritten RAM contents are undefined.
- Reset mid-frame: counters return to (0,0) on the next edge and outputs go to their reset values. RAM contents are preserved.

Decomposition:
- Package vga_pkg: default timing constants, H_LINE/V_LINE/MEM_SIZE derivation functions, and a pixel struct {red, green, blue}.
- Sub-module vga_timing_gen: counters, visible flag, sync decode and read address.
- Top level instantiates vga_timing_gen, an inferred simple dual-port RAM, and the output register stage.

Test Plan:
- Params 320x240, porches/syncs 5 each (H_LINE=335, V_LINE=255). Hold reset, write RAM[x*240+y] = x*240+y mod 4096, release -> over a full frame pixel_out at cycle k equals the expected value for (x,y) of cycle k-1; 0 outside the visible area.
- Same setup, count h_sync -> low exactly for h_cnt 325..329 (5 cycles) every 335 cycles. v_sync low for lines 245..249, i.e. 1675 cycles, period 85425 cycles.
- Reset asserted -> pixel_out=0, h_sync=1, v_sync=1. First edge after release -> pixel_out=RAM[0].
- Write 12'hABC to addr 241 (x=1, y=1) mid-frame after (1,1) has already been scanned -> the new value appears at (1,1) in the next frame only. Write to addr 76800 -> no effect.
- Assert reset for 1 cycle mid-line at h_cnt=100 -> scan restarts at (0,0) and RAM data is unchanged.
- Write to addr 0 in the same cycle it is being read -> old value displayed this frame, new value next frame.
